hazard_controller: RTL
======================

Name: hazard_controller

Overview:
Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It generates forwarding selects for the Execute-stage operand muxes, load-use stalls and branch flushes. It sequences multi-cycle Execute operations through a start/done handshake with a timeout, freezing F/D/E while the operation runs. It also keeps saturating stall/flush event counters for performance debug.

Parameters:
MC_TIMEOUT, 64, max BUSY cycles before a multi-cycle op is force-released (>=2)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
Rs1D  input  5  rs1 address of instruction in D
Rs2D  input  5  rs2 address of instruction in D
Rs1E  input  5  rs1 address in E
Rs2E  input  5  rs2 address in E
RdE  input  5  destination address in E
RdM  input  5  destination address in M
RdW  input  5  destination address in W
RegWriteM  input  1  M-stage register write enable
RegWriteW  input  1  W-stage register write enable
ResultSrcE  input  1  E-stage instruction is a load
PCSrcE  input  1  branch/jump taken, resolved in E
MulReqE  input  1  E-stage instruction needs the multi-cycle unit
MulDone  input  1  multi-cycle unit result valid (1-cycle pulse)
CntClr  input  1  synchronous clear of counters
ForwardAE  output  2  operand A select: 00 RD1_E, 01 ResultW, 10 ALUResultM
ForwardBE  output  2  operand B select, same encoding
StallF  output  1  hold PC
StallD  output  1  hold F/D register
StallE  output  1  hold D/E register
FlushD  output  1  clear F/D register
FlushE  output  1  clear D/E register (insert bubble)
MulStart  output  1  start pulse to multi-cycle unit
McBusy  output  1  FSM in BUSY
McError  output  1  sticky timeout flag
StallCnt  output  CNT_W  cycles with StallF=1
FlushCnt  output  CNT_W  cycles with FlushE=1

Behaviour:
- Reset (rst=0, async): state IDLE, timeout counter 0, McError=0, StallCnt=FlushCnt=0. All other outputs are combinational from state and inputs; in IDLE with all inputs 0 every output is 0.
- Forwarding (combinational, per operand; Rs1E shown):
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else 00.
  - M has priority over W. Register x0 never forwards.
- lwStall = ResultSrcE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY when MulReqE & ~PCSrcE. MulStart=1 only in that cycle (combinational). MulDone is ignored in IDLE.
  - BUSY -> IDLE on MulDone, or when the timeout counter reaches MC_TIMEOUT-1. The timeout case also sets McError=1.
  - The timeout counter clears on entry to BUSY and increments each BUSY cycle.
- Stall/flush equations:
  - hold = McBusy & ~MulDone & ~timeout_now.
  - StallF = lwStall | hold | MulStart.
  - StallD = same as StallF.
  - StallE = hold | MulStart.
  - FlushD = PCSrcE & ~hold.
  - FlushE = (lwStall | PCSrcE) & ~hold & ~MulStart.
  - Consequences: the cycle of MulDone or timeout releases F/D/E in the same cycle, and the E instruction advances. While held, no flush is issued.
- McError is cleared only by reset.
- Counters: each increments by 1 per qualifying cycle and saturates at 2^CNT_W-1. CntClr zeroes both and takes priority over increment in the same cycle.
- Reset mid-BUSY: returns to IDLE at once, and all stalls drop.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01. Then RdW=0, Rs1E=0 -> 00.
- Load-use: ResultSrcE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1, StallE=0. With RdE=0 -> all 0. StallCnt and FlushCnt increment by 1.
- Branch: PCSrcE=1 -> FlushD=FlushE=1 for exactly that cycle, StallF=0.
- Multi-cycle op: MulReqE=1 at cycle 0, MulDone at cycle 4.
  - Cycle 0: MulStart=1.
  - Cycles 1-3: McBusy=1 and StallF/D/E=1.
  - Cycle 4: stalls=0.
  - Cycle 5: state IDLE.
  - McError=0 throughout.
- Timeout: MC_TIMEOUT=8, MulReqE held, MulDone never asserted -> BUSY lasts 8 cycles, stalls release on the 8th, and McError=1 sticky thereafter. Also check CntClr zeroes the counters and that a counter saturates with CNT_W=4 after 15 stalls.
- Reset asserted during BUSY -> McBusy, stalls and counters go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Purpose: groups the hazard controller's pipeline-side signals into one bundle.
// Ports: register addresses and write enables from D/E/M/W, branch and
//        multi-cycle handshake inputs; forwarding selects, stall/flush,
//        multi-cycle status and performance counters as outputs.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             ResultSrcE;
  logic             PCSrcE;
  logic             MulReqE;
  logic             MulDone;
  logic             CntClr;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             MulStart;
  logic             McBusy;
  logic             McError;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  // Pipeline side drives addresses/requests and observes hazard controls.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MulReqE, MulDone, CntClr,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           MulStart, McBusy, McError, StallCnt, FlushCnt
  );

  // Hazard controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MulReqE, MulDone, CntClr,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           MulStart, McBusy, McError, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Purpose: forwarding selects, load-use stall, branch flush and multi-cycle op
//          sequencing (start/done with timeout) for a 5-stage RISC-V pipeline.
// Ports: clk, rst (async active-low), hz (slave side of hazard_controller_if).
//        Hazard outputs are combinational, same cycle; only state, timeout
//        count, sticky error and the saturating counters are registered.
module hazard_controller #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_controller_if.slave   hz
);

  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            timeout_now;
  logic            lw_stall;
  logic            hold;
  logic            mul_start;
  logic            mc_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // M-stage result is newer than W, so it wins; x0 is hardwired zero.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  assign lw_stall = hz.ResultSrcE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  assign timeout_now = (state == BUSY) && (tmo_cnt == TMO_LAST);

  // A taken branch in E kills the multi-cycle request, so no start is issued.
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        if (hz.MulReqE && !hz.PCSrcE) begin
          mul_start = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (hz.MulDone || timeout_now)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Held at zero in IDLE so every BUSY episode starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                tmo_cnt <= '0;
    else if (state == BUSY)  tmo_cnt <= tmo_cnt + TW'(1);
    else                     tmo_cnt <= '0;
  end

  // Sticky until reset; a done arriving on the last cycle is not an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           mc_error <= 1'b0;
    else if (timeout_now && !hz.MulDone) mc_error <= 1'b1;
  end

  // The release cycle (done or timeout) lets E advance immediately.
  assign hold = (state == BUSY) && !hz.MulDone && !timeout_now;

  assign hz.MulStart = mul_start;
  assign hz.McBusy   = (state == BUSY);
  assign hz.McError  = mc_error;
  assign hz.StallF   = lw_stall || hold || mul_start;
  assign hz.StallD   = lw_stall || hold || mul_start;
  assign hz.StallE   = hold || mul_start;
  assign hz.FlushD   = hz.PCSrcE && !hold;
  assign hz.FlushE   = (lw_stall || hz.PCSrcE) && !hold && !mul_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.CntClr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.StallF && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (hz.FlushE && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;

endmodule
